i2c_master_rx: RTL

Single-clock I2C bus master that issues read transactions and sits directly upstream of `i2c_slave`: it generates `scl` and the slave's `sda_in`, and samples the slave's `sda_out`. A host requests a read of 0–15 bytes from a 7-bit address. The block emits the start condition, the address byte with R/W=1, per-byte master ACK/NACK and the stop condition, and presents each received byte with a one-cycle valid strobe.

---
 rtl/i2c_master_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/i2c_master_rx.sv
// I2C read master: START, address+R, ACK check, N data bytes with master ACK/NACK, STOP.
// Optional SCL clock stretching is compiled in with I2C_MASTER_CLK_STRETCH_EN.
module i2c_master_rx #(
    parameter int SCL_PERIOD = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_req,
    input  logic [6:0] slave_addr,
    input  logic [3:0] num_bytes,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       scl,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       nack_err
);
    // state  | meaning
    // IDLE   | bus released, waiting for start_req
    // START  | SDA falls while SCL high
    // ADDR   | shift out {slave_addr, 1'b1}
    // AACK   | sample slave address acknowledge
    // DATA   | shift in one byte
    // MACK   | master ACK (more bytes) or NACK (last byte)
    // STOP   | SDA rises while SCL high
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_MACK, S_STOP
    } state_t;

    localparam int PW = $clog2(SCL_PERIOD);
    localparam logic [PW-1:0] Q1_PRE = PW'(SCL_PERIOD / 4 - 1);
    localparam logic [PW-1:0] H      = PW'(SCL_PERIOD / 2);
    localparam logic [PW-1:0] H_PRE  = PW'(SCL_PERIOD / 2 - 1);
    localparam logic [PW-1:0] Q3     = PW'(3 * SCL_PERIOD / 4);
    localparam logic [PW-1:0] Q3_PRE = PW'(3 * SCL_PERIOD / 4 - 1);
    localparam logic [PW-1:0] LAST   = PW'(SCL_PERIOD - 1);

    state_t        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [2:0]    bit_cnt;
    logic [3:0]    byte_cnt;
    logic [7:0]    addr_sh;
    logic [6:0]    rx_sh;
    logic          sda_q;
    logic          ack_bit;
    logic          hold;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    assign hold = (state != S_IDLE) && (phase == H) && !scl_in;
`else
    logic scl_in_unused;
    assign scl_in_unused = scl_in;
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= S_IDLE;
            phase <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        if (state == S_IDLE) begin
            phase_nxt = '0;
            if (start_req) state_nxt = S_START;
        end else begin
            if (hold)               phase_nxt = phase;
            else if (phase == LAST) phase_nxt = '0;
            else                    phase_nxt = phase + 1'b1;
            if (phase == LAST) begin
                case (state)
                    S_START: state_nxt = S_ADDR;
                    S_ADDR:  if (bit_cnt == 3'd7) state_nxt = S_AACK;
                    S_AACK:  state_nxt = (ack_bit || byte_cnt == 4'd0) ? S_STOP : S_DATA;
                    S_DATA:  if (bit_cnt == 3'd7) state_nxt = S_MACK;
                    S_MACK:  state_nxt = (byte_cnt == 4'd1) ? S_STOP : S_DATA;
                    S_STOP:  state_nxt = S_IDLE;
                    default: state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // SDA is loaded one cycle early so it is visible exactly at Q1 (or H for START)
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            addr_sh  <= '0;
            rx_sh    <= '0;
            sda_q    <= 1'b1;
            ack_bit  <= 1'b1;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            nack_err <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            nack_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        addr_sh  <= {slave_addr, 1'b1};
                        byte_cnt <= num_bytes;
                        bit_cnt  <= '0;
                    end
                end
                S_START: begin
                    if (phase == H_PRE) sda_q <= 1'b0;
                end
                S_ADDR: begin
                    if (phase == Q1_PRE) begin
                        sda_q   <= addr_sh[7];
                        addr_sh <= {addr_sh[6:0], 1'b0};
                    end
                    if (phase == LAST) bit_cnt <= bit_cnt + 3'd1;
                end
                S_AACK: begin
                    if (phase == Q1_PRE) sda_q <= 1'b1;
                    if (phase == Q3) begin
                        ack_bit  <= sda_in;
                        nack_err <= sda_in;
                    end
                end
                S_DATA: begin
                    if (phase == Q1_PRE) sda_q <= 1'b1;
                    if (phase == Q3) begin
                        rx_sh <= {rx_sh[5:0], sda_in};
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {rx_sh, sda_in};
                            rx_valid <= 1'b1;
                        end
                    end
                    if (phase == LAST) bit_cnt <= bit_cnt + 3'd1;
                end
                S_MACK: begin
                    if (phase == Q1_PRE) sda_q <= (byte_cnt == 4'd1);
                    if (phase == LAST) byte_cnt <= byte_cnt - 4'd1;
                end
                S_STOP: begin
                    if (phase == Q1_PRE) sda_q <= 1'b0;
                    if (phase == Q3_PRE) sda_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign scl     = (state == S_IDLE || state == S_START) ? 1'b1 : (phase >= H);
    assign sda_out = sda_q;
    assign busy    = (state != S_IDLE);

endmodule
